// File: rtl/move_collector_pkg.sv
// Shared move-word layout, collector sizing and collector state encodings.
package move_collector_pkg;

    localparam int NSQ   = 64;
    localparam int MVW   = 19;
    localparam int SLOTS = 8;
    localparam int FIFOW = 160;
    localparam int CNTW  = 8;
    localparam int SELW  = 6;
    localparam int SLOTW = 3;
    localparam int PACKW = SLOTS * MVW;

    // Move field bit positions.
    localparam int INV    = 18;
    localparam int PROMO  = 17;
    localparam int PAWN   = 16;
    localparam int PAWN2  = 15;
    localparam int EP     = 14;
    localparam int CASTLE = 13;
    localparam int CAP    = 12;

    localparam int FROM_HI = 11;
    localparam int FROM_LO = 6;
    localparam int TO_HI   = 5;
    localparam int TO_LO   = 0;

    localparam logic [MVW-1:0] IMOV = {1'b1, {(MVW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAITD = 3'd1,
        S_SCAN  = 3'd2,
        S_READ  = 3'd3,
        S_LATCH = 3'd4,
        S_EMIT  = 3'd5,
        S_FIN   = 3'd6
    } state_e;

endpackage

// File: rtl/move_collector_slot_unpacker.sv
// Selects one 19-bit move slot out of a latched FIFO word and flags it valid.
module move_collector_slot_unpacker
    import move_collector_pkg::*;
(
    input  logic [PACKW-1:0] word_i,
    input  logic [SLOTW-1:0] slot_i,
    output logic [MVW-1:0]   move_o,
    output logic             valid_o
);

    logic [7:0] base;

    always_comb begin
        base    = 8'(slot_i) * 8'(MVW);
        move_o  = word_i[base +: MVW];
        valid_o = ~move_o[INV];
    end

endmodule

// File: rtl/move_collector.sv
// Drains the per-square move FIFOs in square order once every square is done,
// streaming valid moves downstream and counting moves and captures.
module move_collector
    import move_collector_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NSQ-1:0]   sq_done,
    input  logic [NSQ-1:0]   sq_empty,
    input  logic [FIFOW-1:0] sq_data,
    output logic [SELW-1:0]  sq_sel,
    output logic             sq_rden,
    output logic             mv_valid,
    output logic [MVW-1:0]   mv_data,
    input  logic             mv_ready,
    output logic [CNTW-1:0]  move_count,
    output logic [CNTW-1:0]  cap_count,
    output logic             busy,
    output logic             done,
    output state_e           state_dbg
);

    state_e             state_q, state_d;
    logic [SELW-1:0]    sel_q, sel_d;
    logic [SLOTW-1:0]   slot_q, slot_d;
    logic [PACKW-1:0]   word_q, word_d;
    logic [CNTW-1:0]    mcnt_q, mcnt_d;
    logic [CNTW-1:0]    ccnt_q, ccnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [MVW-1:0]     slot_move;
    logic               slot_valid;
    logic               unused_pad;

    assign unused_pad = ^sq_data[FIFOW-1:PACKW];

    move_collector_slot_unpacker u_unpack (
        .word_i  (word_q),
        .slot_i  (slot_q),
        .move_o  (slot_move),
        .valid_o (slot_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            slot_q  <= '0;
            word_q  <= '0;
            mcnt_q  <= '0;
            ccnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            slot_q  <= slot_d;
            word_q  <= word_d;
            mcnt_q  <= mcnt_d;
            ccnt_q  <= ccnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Handshake: a move transfers on a clock edge where mv_valid && mv_ready;
    // once raised, mv_valid and mv_data hold unchanged until that transfer.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        slot_d   = slot_q;
        word_d   = word_q;
        mcnt_d   = mcnt_q;
        ccnt_d   = ccnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        sq_rden  = 1'b0;
        mv_valid = 1'b0;
        mv_data  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAITD;
                    mcnt_d  = '0;
                    ccnt_d  = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_WAITD: begin
                if (&sq_done) begin
                    state_d = S_SCAN;
                    sel_d   = '0;
                end
            end
            S_SCAN: begin
                if (!sq_empty[sel_q]) begin
                    state_d = S_READ;
                end else if (sel_q == SELW'(NSQ - 1)) begin
                    state_d = S_FIN;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            S_READ: begin
                sq_rden = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                word_d  = sq_data[PACKW-1:0];
                slot_d  = SLOTW'(SLOTS - 1);
                state_d = S_EMIT;
            end
            S_EMIT: begin
                mv_valid = slot_valid;
                mv_data  = slot_valid ? slot_move : '0;
                if (!slot_valid || mv_ready) begin
                    if (slot_valid) begin
                        if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
                        if (slot_move[CAP] && ccnt_q != '1) ccnt_d = ccnt_q + 1'b1;
                    end
                    // The same square is rescanned: its FIFO may hold more words.
                    if (slot_q == '0) state_d = S_SCAN;
                    else              slot_d  = slot_q - 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sq_sel     = sel_q;
    assign move_count = mcnt_q;
    assign cap_count  = ccnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_move_collector.sv
// Self-checking bench for move_collector: FIFO model per square, stream
// monitor, and a reference model that flattens loaded words into expected moves.
module tb_move_collector;
    import move_collector_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mv_ready = 1'b1;
    logic [63:0]   sq_done = '1;
    logic [63:0]   sq_empty;
    logic [159:0]  sq_data = '0;
    logic [5:0]    sq_sel;
    logic          sq_rden;
    logic          mv_valid;
    logic [18:0]   mv_data;
    logic [7:0]    move_count;
    logic [7:0]    cap_count;
    logic          busy;
    logic          done;
    state_e        state_dbg;

    always #5 clk = ~clk;

    move_collector dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sq_done    (sq_done),
        .sq_empty   (sq_empty),
        .sq_data    (sq_data),
        .sq_sel     (sq_sel),
        .sq_rden    (sq_rden),
        .mv_valid   (mv_valid),
        .mv_data    (mv_data),
        .mv_ready   (mv_ready),
        .move_count (move_count),
        .cap_count  (cap_count),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Upstream FIFOs: one circular store per square, non-show-ahead read.
    logic [159:0] mem [64][64];
    int           wr_cnt [64] = '{default: 0};
    int           rd_ptr [64] = '{default: 0};

    always_comb begin
        for (int i = 0; i < 64; i++) sq_empty[i] = (rd_ptr[i] == wr_cnt[i]);
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) rd_ptr[i] <= wr_cnt[i];
        end else if (sq_rden && rd_ptr[sq_sel] != wr_cnt[sq_sel]) begin
            sq_data <= mem[sq_sel][rd_ptr[sq_sel] % 64];
            rd_ptr[sq_sel] <= rd_ptr[sq_sel] + 1;
        end
    end

    // Stream and read-strobe monitor.
    logic [18:0] obs [2048];
    int          obs_n = 0;
    int          rden_total = 0;
    int          rden_cnt [64] = '{default: 0};
    int          emit_cycles = 0;
    int          hold_viol = 0;
    int          empty_viol = 0;
    int          notdone_viol = 0;
    logic        stall_q = 1'b0;
    logic [18:0] stall_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q && !(mv_valid === 1'b1 && mv_data === stall_data)) hold_viol <= hold_viol + 1;
            stall_q    <= mv_valid && !mv_ready;
            stall_data <= mv_data;
            if (mv_valid && mv_ready) begin
                obs[obs_n % 2048] <= mv_data;
                obs_n <= obs_n + 1;
            end
            if (sq_rden) begin
                rden_total <= rden_total + 1;
                rden_cnt[sq_sel] <= rden_cnt[sq_sel] + 1;
                if (sq_empty[sq_sel]) empty_viol <= empty_viol + 1;
                if (!(&sq_done)) notdone_viol <= notdone_viol + 1;
            end
            if (state_dbg == S_EMIT) emit_cycles <= emit_cycles + 1;
        end
    end

    // Scoreboard and reference model.
    int           checks = 0;
    int           errors = 0;
    logic [159:0] pass_words [64][$];
    logic [18:0]  exp_q [$];
    int           exp_mc;
    int           exp_cc;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic new_pass();
        for (int i = 0; i < 64; i++) pass_words[i].delete();
    endtask

    task automatic load_word(input int sq, input logic [159:0] w);
        mem[sq][wr_cnt[sq] % 64] = w;
        wr_cnt[sq] = wr_cnt[sq] + 1;
        pass_words[sq].push_back(w);
    endtask

    function automatic logic [159:0] make_word(input int pct);
        logic [159:0] w;
        logic [18:0]  m;
        w = '0;
        w[159:152] = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            m = 19'($urandom);
            m[18] = ($urandom_range(0, 99) >= pct);
            w[19*k +: 19] = m;
        end
        return w;
    endfunction

    function automatic logic [159:0] invalid_word();
        logic [159:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[19*k +: 19] = IMOV;
        return w;
    endfunction

    // Squares ascending, words in FIFO order, slots 7 down to 0, invalid dropped.
    task automatic build_expected();
        logic [159:0] w;
        logic [18:0]  m;
        int           ncap;
        exp_q.delete();
        ncap = 0;
        for (int sq = 0; sq < 64; sq++) begin
            for (int n = 0; n < pass_words[sq].size(); n++) begin
                w = pass_words[sq][n];
                for (int k = 7; k >= 0; k--) begin
                    m = w[19*k +: 19];
                    if (!m[18]) begin
                        exp_q.push_back(m);
                        if (m[12]) ncap++;
                    end
                end
            end
        end
        exp_mc = (exp_q.size() > 255) ? 255 : exp_q.size();
        exp_cc = (ncap > 255) ? 255 : ncap;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int mode);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            mv_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            start = (mode == 2 && cyc == 10);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        mv_ready = 1'b1;
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    endtask

    task automatic compare_stream(input string tag, input int base);
        int n;
        n = obs_n - base;
        check({tag, "_nmoves"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check({tag, "_move"}, 32'(obs[(base + i) % 2048]), 32'(exp_q[i]));
        check({tag, "_move_count"}, 32'(move_count), 32'(exp_mc));
        check({tag, "_cap_count"}, 32'(cap_count), 32'(exp_cc));
    endtask

    task automatic run_pass(input string tag, input int mode);
        int base;
        build_expected();
        base = obs_n;
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'(1));
        wait_done(tag, mode);
        compare_stream(tag, base);
    endtask

    initial begin
        logic [159:0] w;
        logic [18:0]  m;
        int           base, b_emit, b_rd, b_rd0, cyc;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sq_sel), 32'(0));
        check("rst_rden", 32'(sq_rden), 32'(0));
        check("rst_valid", 32'(mv_valid), 32'(0));
        check("rst_data", 32'(mv_data), 32'(0));
        check("rst_mcount", 32'(move_count), 32'(0));
        check("rst_ccount", 32'(cap_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // 1: one pawn move in slot 7 of square 12.
        new_pass();
        m = '0;
        m[PAWN] = 1'b1;
        m[FROM_HI:FROM_LO] = 6'o14;
        m[TO_HI:TO_LO] = 6'o24;
        w = invalid_word();
        w[151:133] = m;
        load_word(12, w);
        base = obs_n;
        run_pass("t1", 0);
        check("t1_literal", 32'(obs[base % 2048]), 32'(19'h10314));
        repeat (3) @(negedge clk);
        check("t1_done_held", 32'(done), 32'(1));
        check("t1_state_idle", 32'(state_dbg), 32'(S_IDLE));

        // 2: capture held under backpressure.
        new_pass();
        w = invalid_word();
        w[151:133] = 19'h010DB;
        load_word(9, w);
        build_expected();
        base = obs_n;
        mv_ready = 1'b0;
        pulse_start();
        cyc = 0;
        while (mv_valid !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("t2_valid_seen", 32'(mv_valid), 32'(1));
        repeat (5) begin
            check("t2_hold_valid", 32'(mv_valid), 32'(1));
            check("t2_hold_data", 32'(mv_data), 32'(19'h010DB));
            @(negedge clk);
        end
        mv_ready = 1'b1;
        wait_done("t2", 0);
        compare_stream("t2", base);
        check("t2_cap_literal", 32'(cap_count), 32'(1));

        // 3: two full words in square 0 at one move per cycle.
        new_pass();
        load_word(0, make_word(100));
        load_word(0, make_word(100));
        b_emit = emit_cycles;
        b_rd = rden_total;
        b_rd0 = rden_cnt[0];
        run_pass("t3", 0);
        check("t3_rden_sq0", 32'(rden_cnt[0] - b_rd0), 32'(2));
        check("t3_rden_total", 32'(rden_total - b_rd), 32'(2));
        check("t3_emit_cycles", 32'(emit_cycles - b_emit), 32'(16));

        // 4: last done flag rises 20 cycles after start.
        new_pass();
        load_word(30, make_word(60));
        load_word(45, make_word(60));
        build_expected();
        base = obs_n;
        b_rd = rden_total;
        sq_done = 64'h7FFF_FFFF_FFFF_FFFF;
        pulse_start();
        repeat (20) @(negedge clk);
        check("t4_no_rden", 32'(rden_total - b_rd), 32'(0));
        check("t4_waitd", 32'(state_dbg), 32'(S_WAITD));
        sq_done = '1;
        @(negedge clk);
        check("t4_scan_next", 32'(state_dbg), 32'(S_SCAN));
        wait_done("t4", 1);
        compare_stream("t4", base);

        // 5: reset while the third move is pending.
        new_pass();
        load_word(7, make_word(100));
        base = obs_n;
        pulse_start();
        cyc = 0;
        while (!(obs_n - base == 2 && mv_valid === 1'b1) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_third_pending", 32'(mv_valid), 32'(1));
        reset = 1'b1;
        #1;
        check("t5_sel", 32'(sq_sel), 32'(0));
        check("t5_rden", 32'(sq_rden), 32'(0));
        check("t5_valid", 32'(mv_valid), 32'(0));
        check("t5_data", 32'(mv_data), 32'(0));
        check("t5_mcount", 32'(move_count), 32'(0));
        check("t5_ccount", 32'(cap_count), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_done", 32'(done), 32'(0));
        check("t5_state", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 6: 300 valid moves saturate move_count.
        new_pass();
        w = make_word(100);
        for (int k = 0; k < 4; k++) w[19*k + 18] = 1'b1;
        load_word(5, w);
        for (int i = 1; i < 10; i++) load_word(5, make_word(100));
        for (int i = 0; i < 10; i++) load_word(20, make_word(100));
        for (int i = 0; i < 9; i++) load_word(40, make_word(100));
        for (int i = 0; i < 9; i++) load_word(63, make_word(100));
        base = obs_n;
        run_pass("t6", 0);
        check("t6_transfers", 32'(obs_n - base), 32'(300));
        check("t6_saturated", 32'(move_count), 32'(255));

        // 7: an all-invalid word costs 8 EMIT cycles and emits nothing.
        new_pass();
        load_word(63, invalid_word());
        b_emit = emit_cycles;
        run_pass("t7", 0);
        check("t7_emit_cycles", 32'(emit_cycles - b_emit), 32'(8));

        // Random passes, random backpressure, a start pulse while busy.
        for (int r = 0; r < 3; r++) begin
            new_pass();
            for (int i = 0; i < 12; i++) load_word($urandom_range(0, 63), make_word(70));
            run_pass("rnd", (r == 0) ? 2 : 1);
        end

        check("rden_never_empty", 32'(empty_viol), 32'(0));
        check("rden_never_notdone", 32'(notdone_viol), 32'(0));
        check("valid_held_until_xfer", 32'(hold_viol), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
